// File: rtl/register_bank_scb.sv
// register_bank_scb: 32x32 register file with same-cycle write bypass and a
// per-register pending-write scoreboard that flags read-after-write hazards.
module register_bank_scb #(
    parameter int DATA_W             = 32,
    parameter int ADDR_W             = 5,
    parameter int ZERO_REG_HARDWIRED = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    rs_addr,
    input  logic [ADDR_W-1:0]    rt_addr,
    output logic [DATA_W-1:0]    rs_data,
    output logic [DATA_W-1:0]    rt_data,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 issue_en,
    input  logic [ADDR_W-1:0]    issue_addr,
    output logic                 rs_busy,
    output logic                 rt_busy,
    output logic                 hazard,
    output logic                 scb_err,
    output logic [2**ADDR_W-1:0] busy_vec
);
    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d, wr_oh, iss_oh;
    logic                err_q, err_d;
    logic                wr_ok, iss_ok;

    // With R0 hardwired, writes and issues to address 0 are dropped entirely,
    // so regs_q[0] and busy_q[0] never leave their reset value of zero.
    assign wr_ok  = wr_en && !(ZERO_REG_HARDWIRED != 0 && wr_addr == '0);
    assign iss_ok = issue_en && !(ZERO_REG_HARDWIRED != 0 && issue_addr == '0);
    assign wr_oh  = wr_ok ? (NUM_REGS'(1) << wr_addr) : '0;
    assign iss_oh = iss_ok ? (NUM_REGS'(1) << issue_addr) : '0;

    // Set after clear: a new issue wins over a same-cycle retirement.
    assign busy_d = (busy_q & ~wr_oh) | iss_oh;
    assign err_d  = err_q | (iss_ok && busy_q[issue_addr] && !(wr_en && wr_addr == issue_addr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (wr_ok) regs_q[wr_addr] <= wr_data;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign rs_data  = (wr_ok && wr_addr == rs_addr) ? wr_data : regs_q[rs_addr];
    assign rt_data  = (wr_ok && wr_addr == rt_addr) ? wr_data : regs_q[rt_addr];
    assign rs_busy  = busy_q[rs_addr] && !(wr_en && wr_addr == rs_addr);
    assign rt_busy  = busy_q[rt_addr] && !(wr_en && wr_addr == rt_addr);
    assign hazard   = rs_busy | rt_busy;
    assign scb_err  = err_q;
    assign busy_vec = busy_q;
endmodule

// File: tb/tb_register_bank_scb.sv
// tb_register_bank_scb: drives an ordinary-R0 and a hardwired-R0 instance with
// the same stimulus and checks both against a behavioural register/scoreboard model.
module tb_register_bank_scb;
    logic        clk = 0;
    logic        rst_n = 1;
    logic [4:0]  rs_addr = 0, rt_addr = 0, wr_addr = 0, issue_addr = 0;
    logic [31:0] wr_data = 0;
    logic        wr_en = 0, issue_en = 0;
    logic [31:0] rs_d [2];
    logic [31:0] rt_d [2];
    logic [31:0] bv [2];
    logic        rsb [2];
    logic        rtb [2];
    logic        hz [2];
    logic        er [2];
    int          vectors = 0, miscompares = 0;
    bit          started = 0;
    logic [31:0] m_reg [2][32];
    bit          m_busy [2][32];
    bit          m_err [2];

    always #5 clk = ~clk;

    register_bank_scb #(.ZERO_REG_HARDWIRED(0)) d0 (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_d[0]), .rt_data(rt_d[0]), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .issue_en(issue_en), .issue_addr(issue_addr),
        .rs_busy(rsb[0]), .rt_busy(rtb[0]), .hazard(hz[0]), .scb_err(er[0]), .busy_vec(bv[0]));

    register_bank_scb #(.ZERO_REG_HARDWIRED(1)) d1 (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_d[1]), .rt_data(rt_d[1]), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .issue_en(issue_en), .issue_addr(issue_addr),
        .rs_busy(rsb[1]), .rt_busy(rtb[1]), .hazard(hz[1]), .scb_err(er[1]), .busy_vec(bv[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_data(int k, logic [4:0] a);
        if (wr_en && !(k == 1 && wr_addr == 0) && wr_addr == a) return wr_data;
        if (k == 1 && a == 0) return 0;
        return m_reg[k][a];
    endfunction

    function automatic bit exp_busy(int k, logic [4:0] a);
        if (k == 1 && a == 0) return 0;
        return m_busy[k][a] && !(wr_en && wr_addr == a);
    endfunction

    function automatic logic [31:0] exp_vec(int k);
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[k][i];
        return v;
    endfunction

    always @(negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[k][i] = 0;
                m_busy[k][i] = 0;
            end
            m_err[k] = 0;
        end
    end

    // Architectural state update: a write stores data and retires the pending op,
    // an issue marks the destination pending; issuing to a pending register with
    // no retiring write is a sticky error.
    always @(posedge clk) begin
        if (rst_n && started) begin
            for (int k = 0; k < 2; k++) begin
                bit wok, iok;
                wok = wr_en && !(k == 1 && wr_addr == 0);
                iok = issue_en && !(k == 1 && issue_addr == 0);
                if (iok && m_busy[k][issue_addr] && !(wr_en && wr_addr == issue_addr)) m_err[k] = 1;
                if (wok) begin
                    m_reg[k][wr_addr] = wr_data;
                    m_busy[k][wr_addr] = 0;
                end
                if (iok) m_busy[k][issue_addr] = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                bit eb, tb;
                eb = exp_busy(k, rs_addr);
                tb = exp_busy(k, rt_addr);
                chk($sformatf("rs_data[%0d]", k), rs_d[k], exp_data(k, rs_addr));
                chk($sformatf("rt_data[%0d]", k), rt_d[k], exp_data(k, rt_addr));
                chk($sformatf("rs_busy[%0d]", k), 32'(rsb[k]), 32'(eb));
                chk($sformatf("rt_busy[%0d]", k), 32'(rtb[k]), 32'(tb));
                chk($sformatf("hazard[%0d]", k), 32'(hz[k]), 32'(eb | tb));
                chk($sformatf("scb_err[%0d]", k), 32'(er[k]), 32'(m_err[k]));
                chk($sformatf("busy_vec[%0d]", k), bv[k], exp_vec(k));
            end
        end
    end

    task automatic step(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input bit ie, input logic [4:0] ia, input logic [4:0] ra, input logic [4:0] rb);
        @(posedge clk);
        #1;
        wr_en = we; wr_addr = wa; wr_data = wd;
        issue_en = ie; issue_addr = ia; rs_addr = ra; rt_addr = rb;
        #1;
    endtask

    function automatic logic [4:0] raddr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        #1 rst_n = 0;
        started = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        step(0, 0, 0, 0, 0, 5, 31);
        chk("reset rs_data", rs_d[0], 0);
        chk("reset rt_data", rt_d[0], 0);
        chk("reset hazard", 32'(hz[0]), 0);
        chk("reset busy_vec", bv[0], 0);
        chk("reset scb_err", 32'(er[0]), 0);

        step(1, 7, 32'hDEADBEEF, 0, 0, 7, 8);
        chk("bypass rs_data", rs_d[0], 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 7, 8);
        chk("stored rs_data", rs_d[0], 32'hDEADBEEF);
        chk("unwritten rt_data", rt_d[0], 0);

        step(0, 0, 0, 1, 3, 3, 8);
        chk("issue same-cycle rs_busy", 32'(rsb[0]), 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 3, 8);
            chk("stall rs_busy", 32'(rsb[0]), 1);
            chk("stall hazard", 32'(hz[0]), 1);
        end
        step(1, 3, 32'h12, 0, 0, 3, 8);
        chk("writeback rs_busy", 32'(rsb[0]), 0);
        chk("writeback rs_data", rs_d[0], 32'h12);
        step(0, 0, 0, 0, 0, 3, 8);
        chk("retired busy_vec[3]", 32'(bv[0][3]), 0);

        step(0, 0, 0, 1, 9, 0, 0);
        step(1, 9, 32'h55, 1, 9, 9, 0);
        step(0, 0, 0, 0, 0, 9, 0);
        chk("reissue busy_vec[9]", 32'(bv[0][9]), 1);
        chk("reissue reg9", rs_d[0], 32'h55);
        chk("reissue scb_err", 32'(er[0]), 0);

        step(1, 0, 32'hFFFF, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("hardwired r0 data", rs_d[1], 0);
        chk("hardwired r0 busy", 32'(rsb[1]), 0);
        chk("ordinary r0 data", rs_d[0], 32'hFFFF);
        chk("ordinary r0 busy", 32'(rsb[0]), 1);

        step(0, 0, 0, 1, 4, 0, 0);
        step(0, 0, 0, 1, 4, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("double issue scb_err", 32'(er[0]), 1);
        step(1, 4, 32'h1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("sticky scb_err", 32'(er[0]), 1);

        step(1, 12, 32'hAB, 1, 12, 0, 0);
        step(0, 0, 0, 0, 0, 12, 0);
        chk("pre-reset reg12", rs_d[0], 32'hAB);
        chk("pre-reset busy12", 32'(rsb[0]), 1);
        #1 rst_n = 0;
        #1;
        chk("async reset busy_vec", bv[0], 0);
        chk("async reset reg12", rs_d[0], 0);
        chk("async reset scb_err", 32'(er[0]), 0);
        @(posedge clk);
        #1 rst_n = 1;

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 1) == 1, raddr(), $urandom(), $urandom_range(0, 3) == 0,
                 raddr(), raddr(), raddr());
            if (n % 600 == 599) begin
                #1 rst_n = 0;
                @(posedge clk);
                #1 rst_n = 1;
            end
        end
        step(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
